i2c_adc_target: RTL and testbench

- I2C target (slave) responder that answers the ADC read protocol our I2C master issues: an address write, a one-byte configuration write, then repeated two-byte conversion reads.
- Serves two purposes:
  - a synthesizable stand-in ADC for board bring-up without the real converter;
  - the bus-accurate counterpart used in the master's testbenches.
- Oversamples SCL/SDA on the system clock. Drives SDA open-drain only: it pulls low or releases, never drives high.

---
 rtl/i2c_pkg.sv | 35 +++
 rtl/i2c_bus_sync.sv | 45 ++++
 rtl/i2c_adc_target.sv | 172 +++++++++++++++++
 tb/tb_i2c_adc_target.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, ACK/NACK bit levels and the
// layout of the 16-bit conversion word returned to the master.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_WAIT_STOP
   } i2c_target_state_t;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   localparam int WORD_W       = 16;
   localparam int WORD_CFG_LSB = 12;
   localparam int WORD_CFG_W   = 2;
   localparam int WORD_SMP_LSB = 0;
   localparam int WORD_SMP_W   = 12;

   // Read word: {2'b00, cfg[1:0], sample[11:0]}
   function automatic logic [WORD_W-1:0] make_word(input logic [WORD_CFG_W-1:0] cfg,
                                                   input logic [WORD_SMP_W-1:0] smp);
      logic [WORD_W-1:0] w;
      w = '0;
      w[WORD_CFG_LSB +: WORD_CFG_W] = cfg;
      w[WORD_SMP_LSB +: WORD_SMP_W] = smp;
      return w;
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with SCL edge strobes and START/STOP detection,
// all derived from the synchronized levels against their previous values.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl,
   input  logic sda_in,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_prev;
   logic                   sda_prev;
   logic                   scl_s;

   // Reset to the idle-bus level so no false edge appears on release
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_prev <= scl_s;
         sda_prev <= sda_s;
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  =  scl_s & ~scl_prev;
   assign scl_fall  = ~scl_s &  scl_prev;
   assign start_det =  scl_s &  scl_prev &  sda_prev & ~sda_s;
   assign stop_det  =  scl_s &  scl_prev & ~sda_prev &  sda_s;

endmodule

// File: rtl/i2c_adc_target.sv
// I2C target emulating the ADC: address byte, configuration writes and
// continuous two-byte conversion reads. SDA is driven open-drain via sda_oe.
module i2c_adc_target import i2c_pkg::*; #(
   parameter logic [6:0] DEV_ADDR    = 7'h28,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic [11:0] sample,
   input  logic        sample_valid,
   output logic [7:0]  config_reg,
   output logic        config_wr,
   output logic        busy
);

   logic sda_s, scl_rise, scl_fall, start_det, stop_det;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst       (rst),
      .scl       (scl),
      .sda_in    (sda_in),
      .sda_s     (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   i2c_target_state_t state;
   logic [2:0]        bit_cnt;
   logic [7:0]        shift_in;
   logic [15:0]       rd_word;
   logic              rd_mode;
   logic              rd_low;
   logic              rd_acked;
   logic [11:0]       holding;
   logic [7:0]        rx_byte;
   logic [7:0]        tx_byte;

   assign rx_byte = {shift_in[6:0], sda_s};
   assign tx_byte = rd_low ? rd_word[7:0] : rd_word[15:8];

   always_ff @(posedge clk) begin
      if (rst) begin
         holding <= 12'h000;
      end else if (sample_valid) begin
         holding <= sample;
      end
   end

   // START/STOP override bit processing; sda_oe otherwise moves only on scl_fall
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         bit_cnt    <= 3'd0;
         sda_oe     <= 1'b0;
         config_reg <= 8'h00;
         config_wr  <= 1'b0;
         busy       <= 1'b0;
         rd_mode    <= 1'b0;
         rd_low     <= 1'b0;
         rd_acked   <= 1'b0;
      end else begin
         config_wr <= 1'b0;
         if (start_det) begin
            state    <= ST_ADDR;
            bit_cnt  <= 3'd0;
            busy     <= 1'b1;
            sda_oe   <= 1'b0;
            rd_acked <= 1'b0;
         end else if (stop_det) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            sda_oe   <= 1'b0;
            rd_acked <= 1'b0;
         end else begin
            case (state)
               ST_ADDR: begin
                  if (scl_rise) begin
                     shift_in <= rx_byte;
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (rx_byte[7:1] == DEV_ADDR) begin
                           state   <= ST_ADDR_ACK;
                           rd_mode <= rx_byte[0];
                           rd_low  <= 1'b0;
                           if (rx_byte[0])
                              rd_word <= make_word(config_reg[5:4], holding);
                        end else begin
                           state <= ST_WAIT_STOP;
                        end
                     end
                  end
               end
               // sda_oe doubles as the phase flag: first fall asserts ACK, second ends it
               ST_ADDR_ACK: begin
                  if (scl_fall) begin
                     if (!sda_oe) begin
                        sda_oe <= 1'b1;
                     end else if (rd_mode) begin
                        state  <= ST_RD_DATA;
                        sda_oe <= ~tx_byte[7];
                     end else begin
                        state  <= ST_WR_DATA;
                        sda_oe <= 1'b0;
                     end
                  end
               end
               ST_WR_DATA: begin
                  if (scl_rise) begin
                     shift_in <= rx_byte;
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        config_reg <= rx_byte;
                        config_wr  <= 1'b1;
                        state      <= ST_WR_ACK;
                     end
                  end
               end
               ST_WR_ACK: begin
                  if (scl_fall) begin
                     if (!sda_oe) begin
                        sda_oe <= 1'b1;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= ST_WR_DATA;
                     end
                  end
               end
               ST_RD_DATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 3'd0) begin
                        sda_oe <= 1'b0;
                        state  <= ST_RD_ACK;
                     end else begin
                        sda_oe <= ~tx_byte[~bit_cnt];
                     end
                  end
               end
               ST_RD_ACK: begin
                  if (scl_rise) begin
                     if (sda_s == I2C_ACK) begin
                        rd_acked <= 1'b1;
                        if (rd_low) begin
                           rd_low  <= 1'b0;
                           rd_word <= make_word(config_reg[5:4], holding);
                        end else begin
                           rd_low <= 1'b1;
                        end
                     end else begin
                        state <= ST_WAIT_STOP;
                     end
                  end else if (scl_fall && rd_acked) begin
                     rd_acked <= 1'b0;
                     state    <= ST_RD_DATA;
                     sda_oe   <= ~tx_byte[7];
                  end
               end
               ST_WAIT_STOP: sda_oe <= 1'b0;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_adc_target.sv
// Bench for i2c_adc_target: a bit-level I2C master model with a read-byte
// scoreboard and counters for config_wr pulses and sda_oe activity.
module tb_i2c_adc_target;

   localparam int Q = 8;  // clk cycles per quarter SCL period

   logic        clk = 1'b0;
   logic        rst;
   logic        scl;
   logic        sda_m;
   logic        sda_bus;
   logic        sda_oe;
   logic [11:0] sample;
   logic        sample_valid;
   logic [7:0]  config_reg;
   logic        config_wr;
   logic        busy;

   int n_chk  = 0;
   int n_pass = 0;
   int wr_cycles = 0;
   int oe_cycles = 0;
   logic [7:0] exp_q[$];

   assign sda_bus = sda_m & ~sda_oe;

   i2c_adc_target #(.DEV_ADDR(7'h28), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .scl          (scl),
      .sda_in       (sda_bus),
      .sda_oe       (sda_oe),
      .sample       (sample),
      .sample_valid (sample_valid),
      .config_reg   (config_reg),
      .config_wr    (config_wr),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (config_wr) wr_cycles <= wr_cycles + 1;
      if (sda_oe)    oe_cycles <= oe_cycles + 1;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_q();
      scl   = 1'b1; wait_q();
      sda_m = 1'b0; wait_q();
      scl   = 1'b0; wait_q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_q();
      scl   = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
   endtask

   task automatic clock_bit(input logic b, output logic seen);
      sda_m = b;    wait_q();
      scl   = 1'b1; wait_q();
      seen  = sda_bus; wait_q();
      scl   = 1'b0; wait_q();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic dummy;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], dummy);
      clock_bit(1'b1, ack);
   endtask

   task automatic read_byte(input string tag, input logic master_ack);
      logic [7:0] d;
      logic       bitv;
      logic [7:0] exp;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, bitv);
         d[i] = bitv;
      end
      clock_bit(master_ack, bitv);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 16'd1, 16'd0);
      end else begin
         exp = exp_q.pop_front();
         check(tag, {8'h00, d}, {8'h00, exp});
      end
   endtask

   initial begin
      logic ack;
      logic dummy;
      int   wr0, oe0;

      rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
      sample = 12'h000; sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
      check("rst_config", {8'd0, config_reg}, 16'h0000);
      check("rst_config_wr", {15'd0, config_wr}, 16'd0);
      check("rst_busy", {15'd0, busy}, 16'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // configuration write
      wr0 = wr_cycles;
      i2c_start();
      check("wr_busy", {15'd0, busy}, 16'd1);
      write_byte(8'h50, ack); check("wr_addr_ack", {15'd0, ack}, 16'd0);
      write_byte(8'h10, ack); check("wr_data_ack", {15'd0, ack}, 16'd0);
      i2c_stop();
      check("wr_config", {8'd0, config_reg}, 16'h0010);
      check("wr_pulse_len", 16'(wr_cycles - wr0), 16'd1);
      check("wr_busy_end", {15'd0, busy}, 16'd0);

      // two-byte read then NACK
      sample = 12'hABC; sample_valid = 1'b1; @(negedge clk); sample_valid = 1'b0;
      exp_q.push_back(8'h1A); exp_q.push_back(8'hBC);
      i2c_start();
      write_byte(8'h51, ack); check("rd_addr_ack", {15'd0, ack}, 16'd0);
      read_byte("rd_hi", 1'b0);
      read_byte("rd_lo", 1'b1);
      oe0 = oe_cycles;
      clock_bit(1'b1, dummy);
      i2c_stop();
      check("rd_release", 16'(oe_cycles - oe0), 16'd0);

      // continuous read, sample updated while byte 2 is in flight
      exp_q.push_back(8'h1A); exp_q.push_back(8'hBC);
      exp_q.push_back(8'h11); exp_q.push_back(8'h23);
      i2c_start();
      write_byte(8'h51, ack); check("cr_addr_ack", {15'd0, ack}, 16'd0);
      read_byte("cr_b0", 1'b0);
      fork
         read_byte("cr_b1", 1'b0);
         begin
            repeat (12 * Q) @(negedge clk);
            sample = 12'h123; sample_valid = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0;
         end
      join
      read_byte("cr_b2", 1'b0);
      read_byte("cr_b3", 1'b1);
      i2c_stop();

      // wrong address
      wr0 = wr_cycles; oe0 = oe_cycles;
      i2c_start();
      write_byte(8'h52, ack); check("bad_addr_nack", {15'd0, ack}, 16'd1);
      check("bad_addr_oe", 16'(oe_cycles - oe0), 16'd0);
      write_byte(8'h77, ack);
      i2c_stop();
      check("bad_addr_cfg", {8'd0, config_reg}, 16'h0010);
      check("bad_addr_wr", 16'(wr_cycles - wr0), 16'd0);

      // repeated START after address write, then read
      wr0 = wr_cycles;
      exp_q.push_back(8'h11); exp_q.push_back(8'h23);
      i2c_start();
      write_byte(8'h50, ack); check("rs_waddr_ack", {15'd0, ack}, 16'd0);
      i2c_start();
      write_byte(8'h51, ack); check("rs_raddr_ack", {15'd0, ack}, 16'd0);
      read_byte("rs_hi", 1'b0);
      read_byte("rs_lo", 1'b1);
      i2c_stop();
      check("rs_no_wr", 16'(wr_cycles - wr0), 16'd0);

      // reset while the target drives a 0 bit (first bit of 0x11)
      i2c_start();
      write_byte(8'h51, ack);
      check("rst_pre_oe", {15'd0, sda_oe}, 16'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_oe", {15'd0, sda_oe}, 16'd0);
      check("rst_mid_busy", {15'd0, busy}, 16'd0);
      check("rst_mid_cfg", {8'd0, config_reg}, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      i2c_stop();

      // recovery after reset
      i2c_start();
      write_byte(8'h50, ack); check("rec_addr_ack", {15'd0, ack}, 16'd0);
      write_byte(8'h22, ack); check("rec_data_ack", {15'd0, ack}, 16'd0);
      i2c_stop();
      check("rec_config", {8'd0, config_reg}, 16'h0022);
      check("sb_drained", 16'(exp_q.size()), 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
